sync_debounce: RTL and testbench
================================

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter pSTAGE, default 3: number of synchronizer flops ahead of the debouncer; legal range 2..8.
REQ-002 Parameter pCNTW, default 16: width of the debounce counter and of iDbTime.
REQ-003 Parameter pRSTVAL, default 1'b0: reset level of the synchronizer chain, the FSM stable state and oLevel.
REQ-004 iClk  input  1  clock; all state updates on its rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-high.
REQ-006 iIn  input  1  asynchronous raw input (pin, switch, foreign-domain level).
REQ-007 iDbTime  input  pCNTW  debounce hold time in cycles; quasi-static, changed only while the FSM is in a STABLE state.
REQ-008 oLevel  output  1  debounced level, registered.
REQ-009 oRise  output  1  one-cycle pulse, registered, coincident with oLevel 0->1.
REQ-010 oFall  output  1  one-cycle pulse, registered, coincident with oLevel 1->0.
REQ-011 oGlitchCnt  output  8  count of rejected transitions (see REQ-024).

Function
REQ-012 iIn SHALL pass through a pSTAGE-deep shift register; s = last stage is the only value the FSM sees.
REQ-013 FSM states SHALL be STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, with an internal counter cnt of pCNTW bits.
REQ-014 STABLE_LO: s=1 -> WAIT_HI, cnt<=0; else hold.
REQ-015 WAIT_HI: s=0 -> STABLE_LO (glitch); s=1 and cnt==iDbTime -> STABLE_HI, oLevel<=1, oRise<=1; else cnt<=cnt+1.
REQ-016 STABLE_HI / WAIT_LO SHALL mirror REQ-014/015 with polarity inverted, producing oLevel<=0 and oFall<=1.
REQ-017 oRise and oFall SHALL be high for exactly one cycle per accepted transition and never simultaneously.
REQ-018 Latency: iIn sampled high at edge E0 and held -> oLevel and oRise high after edge E0+pSTAGE+iDbTime+1 (pSTAGE=3, iDbTime=0 -> 4 edges).
REQ-019 cnt SHALL never wrap; iDbTime = all-ones is legal and yields 2^pCNTW hold cycles.
REQ-020 A glitch in WAIT_x SHALL return to the originating STABLE state with oLevel unchanged and no pulse.
REQ-021 oLevel SHALL change only on STABLE<->WAIT completion transitions, never directly from s.

Reset
REQ-022 iRst high SHALL immediately force: synchronizer stages = pRSTVAL, state = STABLE_HI if pRSTVAL=1 else STABLE_LO, cnt=0, oLevel=pRSTVAL, oRise=0, oFall=0, oGlitchCnt=0.
REQ-023 Reset asserted mid-WAIT SHALL abort the qualification with no pulse during or after reset release; the first post-reset transition restarts from REQ-014/016.

Configuration
REQ-024 Macro SYNC_DEBOUNCE_GLITCH_CNT_EN defined: oGlitchCnt increments by 1 on every WAIT->STABLE glitch return, saturating at 255, cleared only by iRst.
REQ-025 Macro SYNC_DEBOUNCE_GLITCH_CNT_EN undefined: no counter logic; oGlitchCnt tied to 8'd0; all other behaviour identical.

Verification
REQ-026 pSTAGE=3, iDbTime=4, iIn 0->1 held -> oLevel=1 and 1-cycle oRise after the 8th edge; oFall stays 0.
REQ-027 iDbTime=4, iIn high for 3 cycles then low -> oLevel stays 0, no pulses, oGlitchCnt=1 (macro on) / 0 (macro off).
REQ-028 iDbTime=0, iIn 1->0 from STABLE_HI -> oLevel=0 and oFall after 4 edges.
REQ-029 Macro on, 300 glitch pulses of 2 cycles with iDbTime=10 -> oGlitchCnt=255, oLevel unchanged.
REQ-030 iRst pulsed while in WAIT_HI with cnt=3 -> oLevel=pRSTVAL, no oRise; after release iIn held high -> oRise after full REQ-018 latency.
REQ-031 pRSTVAL=1, reset released with iIn=1 -> oLevel=1, no oRise/oFall generated.

Source files
------------

// File: rtl/sync_debounce_if.sv
// Signal bundle for sync_debounce: raw input and hold time in, debounced level,
// edge pulses and glitch count out.
interface sync_debounce_if #(
  parameter int pCNTW = 16
);
  logic             iIn;
  logic [pCNTW-1:0] iDbTime;
  logic             oLevel;
  logic             oRise;
  logic             oFall;
  logic [7:0]       oGlitchCnt;

  modport master (
    output iIn, iDbTime,
    input  oLevel, oRise, oFall, oGlitchCnt
  );

  modport slave (
    input  iIn, iDbTime,
    output oLevel, oRise, oFall, oGlitchCnt
  );
endinterface

// File: rtl/sync_debounce.sv
// Synchronizer chain followed by a four-state debounce FSM with edge pulses.
// Optional rejected-transition counter enabled by SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce #(
  parameter int   pSTAGE  = 3,
  parameter int   pCNTW   = 16,
  parameter logic pRSTVAL = 1'b0
) (
  input  logic          iClk,
  input  logic          iRst,
  sync_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam state_t RST_STATE = pRSTVAL ? STABLE_HI : STABLE_LO;

  logic [pSTAGE-1:0] r_sync;
  logic              w_s;
  state_t            r_state;
  logic [pCNTW-1:0]  r_cnt;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]        r_glitch_cnt;
`endif

  // Stage 0 samples the raw pin; each later stage copies its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < pSTAGE; gi++) begin : g_sync
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          r_sync[gi] <= pRSTVAL;
        end else if (gi == 0) begin
          r_sync[gi] <= bus.iIn;
        end else begin
          r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign w_s = r_sync[pSTAGE-1];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_level <= pRSTVAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      r_glitch_cnt <= 8'd0;
`endif
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (w_s) begin
            r_state <= WAIT_HI;
            r_cnt   <= '0;
          end
        end
        WAIT_HI: begin
          if (!w_s) begin
            r_state <= STABLE_LO;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            if (r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
`endif
          end else if (r_cnt == bus.iDbTime) begin
            // Compare-before-increment means cnt tops out at iDbTime and never wraps.
            r_state <= STABLE_HI;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!w_s) begin
            r_state <= WAIT_LO;
            r_cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (w_s) begin
            r_state <= STABLE_HI;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            if (r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
`endif
          end else if (r_cnt == bus.iDbTime) begin
            r_state <= STABLE_LO;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RST_STATE;
      endcase
    end
  end

  assign bus.oLevel = r_level;
  assign bus.oRise  = r_rise;
  assign bus.oFall  = r_fall;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  assign bus.oGlitchCnt = r_glitch_cnt;
`else
  assign bus.oGlitchCnt = 8'd0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: run-length reference model checked every cycle, plus
// directed latency, glitch, reset-abort and saturation scenarios.
module tb_sync_debounce;

  localparam int STG = 3;
  localparam int CW  = 16;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  localparam int EXP_G1  = 1;
  localparam int EXP_SAT = 255;
`else
  localparam int EXP_G1  = 0;
  localparam int EXP_SAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_debounce_if #(.pCNTW(CW)) bus ();
  sync_debounce_if #(.pCNTW(CW)) bus1 ();

  sync_debounce #(.pSTAGE(STG), .pCNTW(CW), .pRSTVAL(1'b0)) dut (
    .iClk(clk), .iRst(rst), .bus(bus)
  );
  sync_debounce #(.pSTAGE(STG), .pCNTW(CW), .pRSTVAL(1'b1)) dut1 (
    .iClk(clk), .iRst(rst), .bus(bus1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FSM input is the raw input seen STG edges earlier; the level
  // flips once the opposite value has been seen on iDbTime+2 consecutive edges,
  // and any shorter run of the opposite value counts as one glitch.
  logic   m_level, m_rise, m_fall;
  int     m_gcnt;
  longint m_run;
  logic   m_q[$];

  always @(posedge clk or posedge rst) begin
    logic s;
    if (rst) begin
      m_q = {};
      for (int i = 0; i < STG; i++) m_q.push_back(1'b0);
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_run = 0; m_gcnt = 0;
    end else begin
      s = m_q.pop_front();
      m_q.push_back(bus.iIn);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == longint'(bus.iDbTime) + 2) begin
          m_level = s;
          m_rise  = s;
          m_fall  = !s;
          m_run   = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        if (m_gcnt < 255) m_gcnt++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("model_level", bus.oLevel, m_level);
    chk("model_rise", bus.oRise, m_rise);
    chk("model_fall", bus.oFall, m_fall);
    chk("model_glitch_cnt", bus.oGlitchCnt, m_gcnt);
    chk("rise_fall_excl", bus.oRise & bus.oFall, 0);
    chk("rstval1_level", bus1.oLevel, 1);
    chk("rstval1_rise", bus1.oRise, 0);
    chk("rstval1_fall", bus1.oFall, 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive the new level just after a negedge; edge E0 is the next rising edge.
  task automatic edge_test(input string name, input logic lvl, input int exp_edges);
    int  n;
    bit  seen;
    seen = 1'b0;
    n    = 0;
    bus.iIn = lvl;
    for (int i = 1; i <= 64 && !seen; i++) begin
      tick();
      if (lvl ? bus.oRise : bus.oFall) begin
        seen = 1'b1;
        n    = i;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout actual=no_pulse required=pulse", name);
    end else begin
      chk(name, n - 1, exp_edges);
      chk({name, "_level"}, bus.oLevel, lvl);
      chk({name, "_other_pulse"}, lvl ? bus.oFall : bus.oRise, 0);
      tick();
      chk({name, "_pulse_width"}, lvl ? bus.oRise : bus.oFall, 0);
      chk({name, "_level_hold"}, bus.oLevel, lvl);
    end
    $display("[TB] %s: pulse after %0d edges (expected %0d)", name, n - 1, exp_edges);
  endtask

  initial begin
    bus.iIn      = 1'b0;
    bus.iDbTime  = CW'(4);
    bus1.iIn     = 1'b1;
    bus1.iDbTime = '0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_level", bus.oLevel, 0);
    chk("rst_rise", bus.oRise, 0);
    chk("rst_glitch_cnt", bus.oGlitchCnt, 0);
    chk("rst_rstval1_level", bus1.oLevel, 1);
    rst = 1'b0;
    $display("[TB] reset released");
    repeat (5) tick();

    // Rising qualification with hold time 4: STG + 4 + 1 edges after E0.
    edge_test("rise_d4", 1'b1, 8);
    repeat (3) tick();

    // Falling qualification with hold time 0: STG + 0 + 1 edges after E0.
    bus.iDbTime = '0;
    edge_test("fall_d0", 1'b0, 4);
    repeat (3) tick();

    // Three-cycle high pulse is shorter than the 6-edge qualification window.
    bus.iDbTime = CW'(4);
    bus.iIn = 1'b1;
    repeat (3) tick();
    bus.iIn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_no_rise", bus.oRise, 0);
      chk("glitch_no_fall", bus.oFall, 0);
    end
    chk("glitch_level", bus.oLevel, 0);
    chk("glitch_cnt_one", bus.oGlitchCnt, EXP_G1);
    $display("[TB] short pulse rejected: level=%0d glitch_cnt=%0d", bus.oLevel, bus.oGlitchCnt);

    // Reset while qualifying a rise with cnt at 3 (edge E0+6).
    bus.iIn = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("abort_level", bus.oLevel, 0);
    chk("abort_rise", bus.oRise, 0);
    chk("abort_glitch_cnt", bus.oGlitchCnt, 0);
    tick();
    rst = 1'b0;
    $display("[TB] reset during qualification");
    edge_test("rise_after_rst", 1'b1, 8);
    repeat (3) tick();

    // 300 two-cycle low pulses against a hold time of 10 from the high level.
    bus.iDbTime = CW'(10);
    for (int p = 0; p < 300; p++) begin
      bus.iIn = 1'b0;
      repeat (2) tick();
      bus.iIn = 1'b1;
      repeat (2) tick();
    end
    repeat (8) tick();
    chk("sat_glitch_cnt", bus.oGlitchCnt, EXP_SAT);
    chk("sat_level", bus.oLevel, 1);
    $display("[TB] 300 glitch pulses: level=%0d glitch_cnt=%0d", bus.oLevel, bus.oGlitchCnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
